// File: rtl/cla_pkg.sv
// Shared constants and flag bundle for the pipelined carry-lookahead adder.
package cla_pkg;

   localparam int CLA_GROUP_W = 4;
   localparam int MAX_STAGES  = 4;

   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
   } cla_flags_t;

endpackage

// File: rtl/cla4_group.sv
// 4-bit carry-lookahead slice: internal carries from per-bit G/P, plus the
// group propagate/generate terms used by the second-level lookahead.
module cla4_group
   import cla_pkg::*;
(
   input  logic [CLA_GROUP_W-1:0] a,
   input  logic [CLA_GROUP_W-1:0] b,
   input  logic                   cin,
   output logic [CLA_GROUP_W-1:0] s,
   output logic                   pg,
   output logic                   gg,
   output logic                   cout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

   assign s    = p ^ c;
   assign pg   = &p;
   assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign cout = gg | (pg & cin);

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor: one carry segment per stage, operands travel
// skewed through the pipe, flags are formed on the assembled sum in the last stage.
module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int SEG = WIDTH / STAGES;
   localparam int NG  = SEG / CLA_GROUP_W;

   if (STAGES < 1 || STAGES > MAX_STAGES || (WIDTH % (CLA_GROUP_W * STAGES)) != 0) begin : g_param_check
      $error("pipelined_cla_adder: WIDTH must be a multiple of 4*STAGES and STAGES in 1..4");
   end

   // Handshake: a transfer happens on a rising edge where valid & ready are both
   // high; valid never depends on ready, and a stalled output holds its payload.
   logic [STAGES-1:0]            v_q, v_d, load;
   logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [STAGES-1:0]            c_q, c_d;
   cla_flags_t                   flags_q, flags_d;

   logic [STAGES-1:0]            st_v, st_cin;
   logic [STAGES-1:0][WIDTH-1:0] st_a, st_b, st_sum;
   logic [STAGES-1:0][SEG-1:0]   seg_s;
   logic [STAGES-1:0]            seg_cout;
   logic                         seg_cmsb;
   logic                         unused_pipe;

   always_comb begin
      st_v      = '0;
      st_cin    = '0;
      st_a      = '0;
      st_b      = '0;
      st_sum    = '0;
      st_v[0]   = in_valid;
      st_a[0]   = a;
      st_b[0]   = sub ? ~b : b;
      st_cin[0] = sub | cin;
      for (int k = 1; k < STAGES; k++) begin
         st_v[k]   = v_q[k-1];
         st_a[k]   = a_q[k-1];
         st_b[k]   = b_q[k-1];
         st_cin[k] = c_q[k-1];
         st_sum[k] = sum_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [NG-1:0]  grp_p, grp_g, grp_co, grp_c;
      logic [SEG-1:0] seg_sum;
      logic           unused_grp_co;

      // Second-level lookahead in sum-of-products form, so no carry ripples group to group.
      always_comb begin
         logic acc;
         logic pp;
         grp_c = '0;
         acc   = 1'b0;
         pp    = 1'b1;
         for (int j = 0; j < NG; j++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int i = j - 1; i >= 0; i--) begin
               acc = acc | (grp_g[i] & pp);
               pp  = pp & grp_p[i];
            end
            grp_c[j] = acc | (pp & st_cin[k]);
         end
      end

      for (genvar j = 0; j < NG; j++) begin : g_grp
         cla4_group u_grp (
            .a    (st_a[k][k*SEG + j*CLA_GROUP_W +: CLA_GROUP_W]),
            .b    (st_b[k][k*SEG + j*CLA_GROUP_W +: CLA_GROUP_W]),
            .cin  (grp_c[j]),
            .s    (seg_sum[j*CLA_GROUP_W +: CLA_GROUP_W]),
            .pg   (grp_p[j]),
            .gg   (grp_g[j]),
            .cout (grp_co[j])
         );
      end

      assign seg_s[k]      = seg_sum;
      assign seg_cout[k]   = grp_co[NG-1];
      assign unused_grp_co = ^grp_co;
   end

   // Carry into the MSB recovered from the sum bit: s = a ^ b ^ c.
   assign seg_cmsb = seg_s[STAGES-1][SEG-1] ^ st_a[STAGES-1][WIDTH-1] ^ st_b[STAGES-1][WIDTH-1];

   always_comb begin
      load           = '0;
      load[STAGES-1] = !v_q[STAGES-1] | out_ready;
      for (int k = STAGES - 2; k >= 0; k--) begin
         load[k] = !v_q[k] | load[k+1];
      end
      v_d     = v_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      sum_d   = sum_q;
      flags_d = flags_q;
      for (int k = 0; k < STAGES; k++) begin
         if (load[k]) begin
            v_d[k]                 = st_v[k];
            a_d[k]                 = st_a[k];
            b_d[k]                 = st_b[k];
            c_d[k]                 = seg_cout[k];
            sum_d[k]               = st_sum[k];
            sum_d[k][k*SEG +: SEG] = seg_s[k];
         end
      end
      if (load[STAGES-1]) begin
         flags_d.cout = seg_cout[STAGES-1];
         flags_d.ovf  = seg_cout[STAGES-1] ^ seg_cmsb;
         flags_d.zero = (sum_d[STAGES-1] == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         sum_q   <= '0;
         flags_q <= '0;
      end else begin
         v_q     <= v_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         sum_q   <= sum_d;
         flags_q <= flags_d;
      end
   end

   assign in_ready    = !v_q[0] | load[0];
   assign out_valid   = v_q[STAGES-1];
   assign sum         = sum_q[STAGES-1];
   assign cout        = flags_q.cout;
   assign ovf         = flags_q.ovf;
   assign zero        = flags_q.zero;
   assign unused_pipe = ^{a_q, b_q, c_q};

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed and random traffic on a 32/2 instance,
// plus random traffic on 16/1 and 64/4 instances, against an arithmetic model.
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // main instance: WIDTH=32, STAGES=2
  logic m_in_valid, m_in_ready, m_cin, m_sub, m_out_valid, m_out_ready;
  logic m_cout, m_ovf, m_zero;
  logic [31:0] m_a, m_b, m_sum;
  // p instance: WIDTH=16, STAGES=1
  logic p_in_valid, p_in_ready, p_cin, p_sub, p_out_valid, p_out_ready;
  logic p_cout, p_ovf, p_zero;
  logic [15:0] p_a, p_b, p_sum;
  // q instance: WIDTH=64, STAGES=4
  logic q_in_valid, q_in_ready, q_cin, q_sub, q_out_valid, q_out_ready;
  logic q_cout, q_ovf, q_zero;
  logic [63:0] q_a, q_b, q_sum;

  // {cout, ovf, zero, sum[63:0]}
  logic [66:0] m_exp_q[$];
  logic [66:0] p_exp_q[$];
  logic [66:0] q_exp_q[$];
  int p_t_q[$];
  int q_t_q[$];
  int m_accepted = 0, m_drained = 0, p_acc = 0, p_drn = 0, q_acc = 0, q_drn = 0;
  logic stall_prev = 1'b0;
  logic [66:0] stall_val = '0;

  pipelined_cla_adder #(.WIDTH(32), .STAGES(2)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .cin(m_cin), .sub(m_sub), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .sum(m_sum), .cout(m_cout), .ovf(m_ovf), .zero(m_zero));

  pipelined_cla_adder #(.WIDTH(16), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .a(p_a), .b(p_b), .cin(p_cin), .sub(p_sub), .out_valid(p_out_valid),
    .out_ready(p_out_ready), .sum(p_sum), .cout(p_cout), .ovf(p_ovf), .zero(p_zero));

  pipelined_cla_adder #(.WIDTH(64), .STAGES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(q_in_valid), .in_ready(q_in_ready),
    .a(q_a), .b(q_b), .cin(q_cin), .sub(q_sub), .out_valid(q_out_valid),
    .out_ready(q_out_ready), .sum(q_sum), .cout(q_cout), .ovf(q_ovf), .zero(q_zero));

  // Reference: plain modular arithmetic on a w-bit operand pair.
  function automatic logic [66:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub, input int w);
    logic [64:0] mask, full;
    logic [63:0] bb, s;
    logic co, ov;
    mask = (65'd1 << w) - 65'd1;
    bb   = sub ? (~b & mask[63:0]) : b;
    full = {1'b0, a} + {1'b0, bb} + {64'd0, (sub ? 1'b1 : cin)};
    s    = full[63:0] & mask[63:0];
    co   = full[w];
    ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    return {co, ov, (s == 64'd0), s};
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_main();
    logic [66:0] cur;
    if (!rst_n) return;
    cur = {m_cout, m_ovf, m_zero, 32'd0, m_sum};
    if (stall_prev) begin
      chk("main_stall_valid", m_out_valid, 1);
      chk("main_stall_hold", cur, stall_val);
    end
    if (m_out_valid && m_out_ready) begin
      chk("main_extra_result", m_exp_q.size() == 0, 0);
      if (m_exp_q.size() > 0) chk("main_result", cur, m_exp_q.pop_front());
      m_drained++;
    end
    if (m_in_valid && m_in_ready) begin
      m_exp_q.push_back(model({32'd0, m_a}, {32'd0, m_b}, m_cin, m_sub, 32));
      m_accepted++;
    end
    stall_prev = m_out_valid && !m_out_ready;
    stall_val  = cur;
  endtask

  task automatic mon_p();
    logic [66:0] cur;
    if (!rst_n) return;
    cur = {p_cout, p_ovf, p_zero, 48'd0, p_sum};
    if (p_out_valid && p_out_ready) begin
      chk("p_extra_result", p_exp_q.size() == 0, 0);
      if (p_exp_q.size() > 0) begin
        chk("p_result", cur, p_exp_q.pop_front());
        chk("p_latency", cyc - p_t_q.pop_front(), 1);
      end
      p_drn++;
    end
    if (p_in_valid && p_in_ready) begin
      p_exp_q.push_back(model({48'd0, p_a}, {48'd0, p_b}, p_cin, p_sub, 16));
      p_t_q.push_back(cyc);
      p_acc++;
    end
  endtask

  task automatic mon_q();
    logic [66:0] cur;
    if (!rst_n) return;
    cur = {q_cout, q_ovf, q_zero, q_sum};
    if (q_out_valid && q_out_ready) begin
      chk("q_extra_result", q_exp_q.size() == 0, 0);
      if (q_exp_q.size() > 0) begin
        chk("q_result", cur, q_exp_q.pop_front());
        chk("q_latency", cyc - q_t_q.pop_front(), 4);
      end
      q_drn++;
    end
    if (q_in_valid && q_in_ready) begin
      q_exp_q.push_back(model(q_a, q_b, q_cin, q_sub, 64));
      q_t_q.push_back(cyc);
      q_acc++;
    end
  endtask

  // Sample at the falling edge, then return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    mon_main();
    mon_p();
    mon_q();
    @(posedge clk);
    #1;
  endtask

  task automatic run_directed(input logic [31:0] a, input logic [31:0] b, input logic cin,
                              input logic sub, output int lat, output logic [34:0] res);
    m_a = a; m_b = b; m_cin = cin; m_sub = sub;
    m_in_valid = 1'b1;
    m_out_ready = 1'b1;
    tick();
    m_in_valid = 1'b0;
    lat = 1;
    while (!m_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    res = {m_cout, m_ovf, m_zero, m_sum};
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acc, stalls, start, n;
    logic [34:0] res;
    m_in_valid = 0; m_a = 0; m_b = 0; m_cin = 0; m_sub = 0; m_out_ready = 1;
    p_in_valid = 0; p_a = 0; p_b = 0; p_cin = 0; p_sub = 0; p_out_ready = 1;
    q_in_valid = 0; q_a = 0; q_b = 0; q_cin = 0; q_sub = 0; q_out_ready = 1;

    // reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", m_out_valid, 0);
    chk("rst_outputs", {m_cout, m_ovf, m_zero, m_sum}, 0);
    chk("rst_q_out_valid", q_out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", m_in_ready, 1);
    chk("rel_out_valid", m_out_valid, 0);

    // wrap to zero
    run_directed(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, lat, res);
    chk("t1_latency", lat, 2);
    chk("t1_flags_sum", res, {1'b1, 1'b0, 1'b1, 32'h0000_0000});

    // signed overflow, then subtraction with borrow
    run_directed(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat, res);
    chk("t2_ovf", res, {1'b0, 1'b1, 1'b0, 32'h8000_0000});
    run_directed(32'd5, 32'd7, 1'b1, 1'b1, lat, res);
    chk("t2_sub", res, {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE});

    // 100 back-to-back ops
    stalls = 0;
    start = m_drained;
    m_out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      m_in_valid = 1'b1;
      m_a = rnd32(); m_b = rnd32();
      m_cin = 1'($urandom_range(0, 1)); m_sub = 1'($urandom_range(0, 1));
      if (!m_in_ready) stalls++;
      tick();
    end
    m_in_valid = 1'b0;
    n = 0;
    while (m_exp_q.size() > 0 && n < 10) begin tick(); n++; end
    chk("t3_count", m_drained - start, 100);
    chk("t3_in_stalls", stalls, 0);
    chk("t3_q_empty", m_exp_q.size(), 0);

    // backpressure: fill with out_ready low
    acc = 0;
    m_out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      m_in_valid = 1'b1;
      m_a = $urandom; m_b = $urandom;
      m_cin = 1'($urandom_range(0, 1)); m_sub = 1'($urandom_range(0, 1));
      if (m_in_ready) acc++;
      tick();
    end
    chk("t4_accepts", acc, 2);
    chk("t4_in_ready", m_in_ready, 0);
    m_in_valid = 1'b0;
    m_out_ready = 1'b1;
    start = m_drained;
    n = 0;
    while (m_exp_q.size() > 0 && n < 10) begin tick(); n++; end
    chk("t4_drained", m_drained - start, 2);
    chk("t4_q_empty", m_exp_q.size(), 0);

    // random valid/ready on both sides
    for (int i = 0; i < 300; i++) begin
      m_in_valid = 1'($urandom_range(0, 1));
      m_out_ready = ($urandom_range(0, 3) != 0);
      m_a = rnd32(); m_b = rnd32();
      m_cin = 1'($urandom_range(0, 1)); m_sub = 1'($urandom_range(0, 1));
      tick();
    end
    m_in_valid = 1'b0;
    m_out_ready = 1'b1;
    n = 0;
    while (m_exp_q.size() > 0 && n < 10) begin tick(); n++; end
    chk("rand_q_empty", m_exp_q.size(), 0);
    chk("rand_balance", m_drained, m_accepted);

    // reset with two ops in flight
    m_out_ready = 1'b1;
    m_a = 32'h1111_1111; m_b = 32'h2222_2222; m_cin = 0; m_sub = 0;
    m_in_valid = 1'b1;
    tick();
    m_a = 32'h3333_3333;
    tick();
    m_in_valid = 1'b0;
    chk("t5_pre_valid", m_out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", m_out_valid, 0);
    chk("t5_rst_outputs", {m_cout, m_ovf, m_zero, m_sum}, 0);
    m_accepted -= m_exp_q.size();
    m_exp_q.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_hold_valid", m_out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_rel_valid", m_out_valid, 0);
    run_directed(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, lat, res);
    chk("t5_latency", lat, 2);
    chk("t5_result", res, {1'b0, 1'b0, 1'b0, 32'h2222_2222});

    // 16/1 and 64/4 instances with random traffic
    for (int i = 0; i < 150; i++) begin
      p_in_valid = ($urandom_range(0, 3) != 0);
      p_a = 16'($urandom); p_b = 16'($urandom);
      p_cin = 1'($urandom_range(0, 1)); p_sub = 1'($urandom_range(0, 1));
      q_in_valid = ($urandom_range(0, 3) != 0);
      q_a = {$urandom, $urandom}; q_b = {$urandom, $urandom};
      if (i % 16 == 0) q_b = ~q_a;
      q_cin = 1'($urandom_range(0, 1)); q_sub = 1'($urandom_range(0, 1));
      tick();
    end
    p_in_valid = 1'b0;
    q_in_valid = 1'b0;
    repeat (8) tick();
    chk("p_q_empty", p_exp_q.size(), 0);
    chk("q_q_empty", q_exp_q.size(), 0);
    chk("p_balance", p_drn, p_acc);
    chk("q_balance", q_drn, q_acc);
    chk("main_final_empty", m_exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
